// File: rtl/regfile_wb_scheduler_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler_if
// Bundles every signal between the write-back scheduler and its neighbours:
//   - ALU and load-unit write-back requests (valid/rd/data) and their readies
//   - issue request (issue_valid/issue_rd) and issue_ready
//   - source-register busy queries (rs1/rs2 -> rs1_busy/rs2_busy)
//   - flush
//   - the registered register-file write port (rf_write_*)
// Modports:
//   slave  - the scheduler itself
//   master - the surrounding pipeline (or a testbench)
// ----------------------------------------------------------------------------
interface regfile_wb_scheduler_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);

   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;

   logic              ld_valid;
   logic [ADDR_W-1:0] ld_rd;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;

   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rd;
   logic              issue_ready;

   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic              rs1_busy;
   logic              rs2_busy;

   logic              flush;

   logic              rf_write_en;
   logic [ADDR_W-1:0] rf_write_register;
   logic [DATA_W-1:0] rf_write_data;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      input  issue_valid, issue_rd,
      input  rs1, rs2, flush,
      output alu_ready, ld_ready, issue_ready,
      output rs1_busy, rs2_busy,
      output rf_write_en, rf_write_register, rf_write_data
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      output issue_valid, issue_rd,
      output rs1, rs2, flush,
      input  alu_ready, ld_ready, issue_ready,
      input  rs1_busy, rs2_busy,
      input  rf_write_en, rf_write_register, rf_write_data
   );

endinterface

// File: rtl/regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler
// Write-back scheduler and scoreboard for the 32 x 64-bit integer register
// file. The ALU and the load unit share the file's single write port through
// a round-robin arbiter; the winning write is registered onto rf_write_*.
// A per-register busy bit records outstanding writes so issue logic can
// interlock on RAW/WAW hazards.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - regfile_wb_scheduler_if.slave (requests, readies, issue,
//          busy queries, flush, register-file write port)
// ----------------------------------------------------------------------------
module regfile_wb_scheduler #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_wb_scheduler_if.slave  bus
);

   typedef enum logic {
      PTR_LD,
      PTR_ALU
   } rr_ptr_t;

   rr_ptr_t             rr_ptr;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic                alu_grant;
   logic                ld_grant;
   logic                issue_fire;

   // Arbitration: a lone requester always wins; when both ask, the round-robin
   // pointer decides. Grants are qualified by valid so ready never appears
   // without a request.
   always_comb begin
      alu_grant = bus.alu_valid & (~bus.ld_valid  | (rr_ptr == PTR_ALU));
      ld_grant  = bus.ld_valid  & (~bus.alu_valid | (rr_ptr == PTR_LD));
   end

   assign bus.alu_ready = alu_grant;
   assign bus.ld_ready  = ld_grant;

   // Issue is refused during flush and while the destination still has a
   // pending write. A register being cleared this cycle still reads busy,
   // which stalls a back-to-back WAW by one cycle.
   assign bus.issue_ready = bus.issue_valid & ~bus.flush &
                            ((bus.issue_rd == '0) | ~busy[bus.issue_rd]);
   assign issue_fire      = bus.issue_ready;

   assign bus.rs1_busy = busy[bus.rs1];
   assign bus.rs2_busy = busy[bus.rs2];

   // The round-robin pointer flips to the loser after every grant, so after
   // an ALU win the load unit is favoured next time and vice versa.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= PTR_LD;
      end else if (alu_grant) begin
         rr_ptr <= PTR_LD;
      end else if (ld_grant) begin
         rr_ptr <= PTR_ALU;
      end
   end

   // Write stage: the granted request is presented to the register file one
   // cycle later. Writes to x0 still consume the port but never raise the
   // write enable. Without a grant only the enable drops; address and data
   // keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rf_write_en       <= 1'b0;
         bus.rf_write_register <= '0;
         bus.rf_write_data     <= '0;
      end else if (alu_grant) begin
         bus.rf_write_en       <= (bus.alu_rd != '0);
         bus.rf_write_register <= bus.alu_rd;
         bus.rf_write_data     <= bus.alu_data;
      end else if (ld_grant) begin
         bus.rf_write_en       <= (bus.ld_rd != '0);
         bus.rf_write_register <= bus.ld_rd;
         bus.rf_write_data     <= bus.ld_data;
      end else begin
         bus.rf_write_en       <= 1'b0;
      end
   end

   // Scoreboard next state: the committing write clears its register on the
   // same edge the file is written, a successful issue sets its destination,
   // and flush wipes everything. Set and clear never collide on one register
   // because issue_ready excludes busy destinations. Bit 0 is pinned low.
   always_comb begin
      busy_next = busy;
      if (bus.rf_write_en) begin
         busy_next[bus.rf_write_register] = 1'b0;
      end
      if (issue_fire && (bus.issue_rd != '0)) begin
         busy_next[bus.issue_rd] = 1'b1;
      end
      if (bus.flush) begin
         busy_next = '0;
      end
      busy_next[0] = 1'b0;
   end

   // Busy bits register the next-state value every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_scheduler
// Directed, self-checking bench for regfile_wb_scheduler. Inputs change one
// time unit after each rising edge; combinational outputs are checked one
// unit after inputs settle, registered outputs one unit after the edge.
// ----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   regfile_wb_scheduler_if #(.DATA_W(64), .ADDR_W(5)) bus ();

   regfile_wb_scheduler #(
      .DATA_W   (64),
      .ADDR_W   (5),
      .NUM_REGS (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive both write-back requesters at once.
   task automatic applyStimulus(input logic av, input logic [4:0] ard,
                                input logic [63:0] ad,
                                input logic lv, input logic [4:0] lrd,
                                input logic [63:0] ldat);
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = ad;
      bus.ld_valid  = lv;
      bus.ld_rd     = lrd;
      bus.ld_data   = ldat;
   endtask

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 5'd0;
      bus.rs1         = 5'd0;
      bus.rs2         = 5'd0;
      bus.flush       = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      checkOutput("reset_wen",  64'(bus.rf_write_en), 64'd0);
      checkOutput("reset_wreg", 64'(bus.rf_write_register), 64'd0);
      checkOutput("reset_wdat", bus.rf_write_data, 64'd0);
      rst     = 1'b0;
      bus.rs1 = 5'd7;
      #1;
      checkOutput("reset_busy7", 64'(bus.rs1_busy), 64'd0);

      // ---------------- single ALU request ----------------
      applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("single_alu_ready", 64'(bus.alu_ready), 64'd1);
      checkOutput("single_ld_ready",  64'(bus.ld_ready), 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      checkOutput("single_wen",  64'(bus.rf_write_en), 64'd1);
      checkOutput("single_wreg", 64'(bus.rf_write_register), 64'd5);
      checkOutput("single_wdat", bus.rf_write_data, 64'h1234);
      tick();
      checkOutput("single_wen_drop", 64'(bus.rf_write_en), 64'd0);
      checkOutput("single_wreg_hold", 64'(bus.rf_write_register), 64'd5);

      // ---------------- contested round robin ----------------
      applyStimulus(1'b1, 5'd1, 64'hA0, 1'b1, 5'd2, 64'hB0);
      #1;
      checkOutput("rr0_ld_ready",  64'(bus.ld_ready), 64'd1);
      checkOutput("rr0_alu_ready", 64'(bus.alu_ready), 64'd0);
      tick();
      bus.ld_data = 64'hB1;
      checkOutput("rr1_wreg", 64'(bus.rf_write_register), 64'd2);
      checkOutput("rr1_wdat", bus.rf_write_data, 64'hB0);
      #1;
      checkOutput("rr1_alu_ready", 64'(bus.alu_ready), 64'd1);
      checkOutput("rr1_ld_ready",  64'(bus.ld_ready), 64'd0);
      tick();
      bus.alu_data = 64'hA1;
      checkOutput("rr2_wreg", 64'(bus.rf_write_register), 64'd1);
      checkOutput("rr2_wdat", bus.rf_write_data, 64'hA0);
      #1;
      checkOutput("rr2_ld_ready", 64'(bus.ld_ready), 64'd1);
      tick();
      bus.ld_data = 64'hB2;
      checkOutput("rr3_wreg", 64'(bus.rf_write_register), 64'd2);
      checkOutput("rr3_wdat", bus.rf_write_data, 64'hB1);
      #1;
      checkOutput("rr3_alu_ready", 64'(bus.alu_ready), 64'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      checkOutput("rr4_wreg", 64'(bus.rf_write_register), 64'd1);
      checkOutput("rr4_wdat", bus.rf_write_data, 64'hA1);
      tick();

      // ---------------- scoreboard on rd=7 ----------------
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd7;
      bus.rs1         = 5'd7;
      bus.rs2         = 5'd7;
      #1;
      checkOutput("sb_issue_ready", 64'(bus.issue_ready), 64'd1);
      checkOutput("sb_busy_before", 64'(bus.rs1_busy), 64'd0);
      tick();
      checkOutput("sb_rs1_busy", 64'(bus.rs1_busy), 64'd1);
      checkOutput("sb_rs2_busy", 64'(bus.rs2_busy), 64'd1);
      checkOutput("sb_waw_stall", 64'(bus.issue_ready), 64'd0);
      bus.issue_valid = 1'b0;
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77);
      #1;
      checkOutput("sb_ld_ready", 64'(bus.ld_ready), 64'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      checkOutput("sb_wen", 64'(bus.rf_write_en), 64'd1);
      checkOutput("sb_wreg", 64'(bus.rf_write_register), 64'd7);
      checkOutput("sb_busy_during_wr", 64'(bus.rs1_busy), 64'd1);
      tick();
      checkOutput("sb_busy_after_wr", 64'(bus.rs1_busy), 64'd0);

      // ---------------- x0 handling ----------------
      applyStimulus(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      checkOutput("x0_wen", 64'(bus.rf_write_en), 64'd0);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd0;
      bus.rs1         = 5'd0;
      #1;
      checkOutput("x0_issue_ready", 64'(bus.issue_ready), 64'd1);
      checkOutput("x0_rs1_busy", 64'(bus.rs1_busy), 64'd0);
      tick();
      bus.issue_valid = 1'b0;
      #1;
      checkOutput("x0_rs1_busy_after", 64'(bus.rs1_busy), 64'd0);

      // ---------------- flush ----------------
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd3;
      tick();
      bus.issue_rd    = 5'd4;
      tick();
      bus.issue_rd    = 5'd9;
      applyStimulus(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      bus.issue_rd = 5'd12;
      bus.flush    = 1'b1;
      bus.rs1      = 5'd3;
      bus.rs2      = 5'd9;
      #1;
      checkOutput("fl_busy3_before", 64'(bus.rs1_busy), 64'd1);
      checkOutput("fl_busy9_before", 64'(bus.rs2_busy), 64'd1);
      checkOutput("fl_issue_ready", 64'(bus.issue_ready), 64'd0);
      checkOutput("fl_wen_commit", 64'(bus.rf_write_en), 64'd1);
      checkOutput("fl_wreg_commit", 64'(bus.rf_write_register), 64'd3);
      checkOutput("fl_wdat_commit", bus.rf_write_data, 64'h33);
      tick();
      bus.flush       = 1'b0;
      bus.issue_valid = 1'b0;
      bus.rs1 = 5'd3;  bus.rs2 = 5'd4;
      #1;
      checkOutput("fl_busy3_after", 64'(bus.rs1_busy), 64'd0);
      checkOutput("fl_busy4_after", 64'(bus.rs2_busy), 64'd0);
      bus.rs1 = 5'd9;  bus.rs2 = 5'd12;
      #1;
      checkOutput("fl_busy9_after", 64'(bus.rs1_busy), 64'd0);
      checkOutput("fl_busy12_after", 64'(bus.rs2_busy), 64'd0);

      // ---------------- asynchronous reset mid-stream ----------------
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd10;
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'h66);
      tick();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      bus.issue_valid = 1'b0;
      bus.rs1         = 5'd10;
      #1;
      checkOutput("rst_pre_wen", 64'(bus.rf_write_en), 64'd1);
      checkOutput("rst_pre_busy10", 64'(bus.rs1_busy), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("rst_async_wen", 64'(bus.rf_write_en), 64'd0);
      checkOutput("rst_async_wreg", 64'(bus.rf_write_register), 64'd0);
      checkOutput("rst_async_busy10", 64'(bus.rs1_busy), 64'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 5'd8, 64'h88, 1'b1, 5'd11, 64'hBB);
      #1;
      checkOutput("rst_rr_ld_ready",  64'(bus.ld_ready), 64'd1);
      checkOutput("rst_rr_alu_ready", 64'(bus.alu_ready), 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      checkOutput("rst_rr_wreg", 64'(bus.rf_write_register), 64'd11);
      checkOutput("rst_rr_wdat", bus.rf_write_data, 64'hBB);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Write-back scheduler and scoreboard for the 32 x 64-bit integer register file.
- Shares the register file's single write port between two producers: the ALU and the load unit.
- Registers the winning write into the file's write_en / write_register / write_data inputs.
- Tracks per-register pending-write (busy) bits, which issue logic uses for RAW/WAW interlocks.

Parameters:
DATA_W, 64, width of write-back data
ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU write-back request
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle
ld_valid  in  1  load-unit write-back request
ld_rd  in  ADDR_W  load destination register
ld_data  in  DATA_W  load data
ld_ready  out  1  load request accepted this cycle
issue_valid  in  1  instruction issuing with a destination register
issue_rd  in  ADDR_W  destination of the issuing instruction
issue_ready  out  1  issue accepted; busy[issue_rd] set
rs1  in  ADDR_W  source register 1 query
rs2  in  ADDR_W  source register 2 query
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
flush  in  1  pipeline flush; clears scoreboard
rf_write_en  out  1  to register file write_en
rf_write_register  out  ADDR_W  to register file write_register
rf_write_data  out  DATA_W  to register file write_data

Behaviour:
- Clock is clk; reset rst is asynchronous and active-high.
- Reset values:
  - rf_write_en=0, rf_write_register=0, rf_write_data=0.
  - All busy bits 0.
  - Round-robin pointer = LD (load has priority on the first contest).
- Arbitration (combinational):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester pointed to by the RR pointer wins; the other sees ready=0.
  - Neither valid: both readies 0.
  - ready is never asserted without the matching valid.
- RR pointer updates on every grant, to point at the non-granted requester.
- Producers hold valid and payload stable until ready. A dropped valid before ready is legal; no state changes.
- Write stage (registered):
  - A grant in cycle N drives rf_write_en=1 with that rd/data in cycle N+1.
  - The register file updates at the edge ending N+1.
  - No grant in cycle N: rf_write_en=0 in N+1; rf_write_register and rf_write_data hold their last values.
- x0 handling:
  - A request with rd=0 is arbitrated and accepted normally (it consumes the port that cycle).
  - rf_write_en stays 0 in N+1 for such a request.
- Scoreboard:
  - One busy bit per register; bit 0 is constant 0.
  - Set: at the edge ending a cycle with issue_valid & issue_ready & issue_rd!=0.
  - Clear: at the edge ending the cycle where rf_write_en=1 for that register.
  - So the busy bit drops on the same edge the file is written, and a consumer sees busy=0 and the new value together.
- rs1_busy / rs2_busy: combinational lookup of the busy bits (0 for x0).
- issue_ready = issue_valid & ~flush & (issue_rd==0 | ~busy[issue_rd]).
  - A register being cleared in the current cycle still reads busy, so issue_ready=0 (conservative WAW stall).
- Simultaneous set and clear of the same register cannot occur, because issue_ready excludes busy registers. Set and clear of different registers in the same cycle both apply.
- flush:
  - Clears all busy bits at the next edge and forces issue_ready=0 that cycle.
  - Does not cancel an rf write already in the output register.
  - Does not affect arbitration.
  - Busy clear from a committing write during flush is moot (all bits clear).
- Reset mid-operation: all state returns to reset values immediately. An in-flight write is lost, and rf_write_en drops asynchronously.

Test Plan:
- Reset, then single ALU request rd=5, data=0x1234:
  - alu_ready=1 same cycle.
  - Next cycle rf_write_en=1, rf_write_register=5, rf_write_data=0x1234.
  - Following cycle rf_write_en=0.
- Both valid for 4 cycles (ALU rd=1, load rd=2, payloads updated on each accept):
  - Grants go LD, ALU, LD, ALU.
  - rf_write_register sequence 2,1,2,1, one cycle behind the grants.
- Scoreboard with issue_rd=7:
  - issue_ready=1; next cycle querying rs1=7 gives rs1_busy=1.
  - A second issue to rd=7 sees issue_ready=0.
  - Load write-back rd=7: rs1_busy=1 through the rf_write_en cycle, 0 the cycle after.
- x0:
  - ALU request rd=0 gets alu_ready=1, but rf_write_en stays 0 next cycle.
  - issue_rd=0 gives issue_ready=1 and no busy change; rs1=0 gives rs1_busy=0 always.
- Flush with rd=3,4,9 busy, a write to rd=3 in the output stage, and issue_valid rd=12 in the same cycle:
  - issue_ready=0.
  - Next cycle all busy=0, including 12.
  - The rd=3 write still commits.
- Assert rst mid-stream while rf_write_en=1:
  - rf_write_en drops without waiting for a clock edge; busy bits all 0.
  - The next contested grant goes to LD.
